// File: rtl/pulse_meter.sv
// ---------------------------------------------------------------------------
// pulse_meter
//
// Receive-side companion to the pulse counter/generator. It watches the
// generator's `pulse` output, in the same clock domain, and classifies what
// it sees:
//   * A lone rising edge with no follower inside TIMEOUT cycles is reported
//     once as a single event on `single_det`.
//   * Two or more rising edges, each within TIMEOUT cycles of the previous
//     one, form a pulse train. `periodic` is held high while the train is
//     tracked, and every edge-to-edge interval is published on `period` with
//     a `period_vld` strobe.
// Only rising edges matter, so pulse width is ignored. Accepted intervals are
// 2..TIMEOUT cycles.
//
// Parameters
//   CW       width of the interval counter and of `period`
//   TIMEOUT  longest accepted edge-to-edge interval, 2 <= TIMEOUT <= 2^CW-1
//   NCW      width of the saturating rising-edge counter `pcount`
//
// Ports
//   clk         in   1    system clock, rising edge
//   rst         in   1    synchronous active-high reset
//   en          in   1    measurement enable. Low forces IDLE and suppresses
//                         strobes, while period/pcount hold their values.
//   pulse       in   1    pulse stream from the generator
//   period      out  CW   last measured interval in cycles
//   period_vld  out  1    one-cycle strobe when `period` is updated
//   periodic    out  1    high while a pulse train is tracked
//   single_det  out  1    one-cycle strobe when a lone pulse times out
//   pcount      out  NCW  accepted rising edges, saturating at all-ones
//   jitter      out  1    (PULSE_METER_JITTER_EN only) one-cycle strobe,
//                         aligned with period_vld, when a train interval
//                         differs from the previously stored period
//
// Build option
//   PULSE_METER_JITTER_EN  defines the `jitter` port and its comparator.
//                          When it is undefined, neither exists.
//
// All outputs are registered. Each output changes exactly one cycle after
// the edge or timeout cycle that causes it.
// ---------------------------------------------------------------------------
module pulse_meter #(
    parameter int CW      = 16,
    parameter int TIMEOUT = 1000,
    parameter int NCW     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           pulse,
    output logic [CW-1:0]  period,
    output logic           period_vld,
    output logic           periodic,
    output logic           single_det,
    output logic [NCW-1:0] pcount
`ifdef PULSE_METER_JITTER_EN
    ,
    output logic           jitter
`endif
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE     = 2'd0;  // waiting for a first edge
    localparam logic [1:0] ST_FIRST    = 2'd1;  // one edge seen, no interval yet
    localparam logic [1:0] ST_PERIODIC = 2'd2;  // train being tracked

    // The counter holds (cycles since last edge) - 1. The last cycle in which
    // an edge is still accepted therefore has cnt == TIMEOUT-1.
    localparam logic [CW-1:0]  CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [NCW-1:0] PCOUNT_MAX = {NCW{1'b1}};

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    // Edge counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [NCW-1:0] sat_inc(input logic [NCW-1:0] v);
        return (v == PCOUNT_MAX) ? v : v + NCW'(1);
    endfunction

    // The interval closed by an edge is the counter value plus one. This
    // cannot overflow, because the counter never exceeds TIMEOUT-1.
    function automatic logic [CW-1:0] interval_of(input logic [CW-1:0] c);
        return c + CW'(1);
    endfunction

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    logic [1:0]     state_q,      state_d;
    logic [CW-1:0]  cnt_q,        cnt_d;
    logic           pulse_prev_q;
    logic [CW-1:0]  period_q,     period_d;
    logic           period_vld_q, period_vld_d;
    logic           periodic_q,   periodic_d;
    logic           single_q,     single_d;
    logic [NCW-1:0] pcount_q,     pcount_d;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    logic rise;      // accepted rising edge in this cycle
    logic tracking;  // an interval is currently open (FIRST or PERIODIC)
    logic timeout;   // the open interval expires in this cycle
    logic meas;      // this edge closes an interval

    always_comb begin
        // pulse_prev_q keeps tracking while en is low. Raising en while pulse
        // is already high therefore never looks like an edge.
        rise     = pulse & ~pulse_prev_q & en;
        tracking = (state_q == ST_FIRST) || (state_q == ST_PERIODIC);
        // An edge that lands on the last accepted cycle takes priority over
        // the timeout. A timeout while disabled is discarded.
        timeout  = en & tracking & (cnt_q == CNT_LAST) & ~rise;
        meas     = rise & tracking;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_FIRST;
            end
            ST_FIRST: begin
                if (rise)         state_d = ST_PERIODIC;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_PERIODIC: begin
                if (timeout) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en) state_d = ST_IDLE;
    end

    always_comb begin
        // The counter restarts on every edge. It rests at zero whenever no
        // interval is open, including the cycle that returns to IDLE.
        cnt_d = cnt_q + CW'(1);
        if (!en || rise || timeout || !tracking) cnt_d = '0;
    end

    always_comb begin
        period_d     = meas ? interval_of(cnt_q) : period_q;
        period_vld_d = meas;
        periodic_d   = (state_d == ST_PERIODIC);
        // The end of a train is not a lone pulse. Only the FIRST-state
        // timeout reports single_det.
        single_d     = timeout & (state_q == ST_FIRST);
        pcount_d     = rise ? sat_inc(pcount_q) : pcount_q;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pulse_prev_q <= 1'b1;  // a pulse already high at release is not an edge
            period_q     <= '0;
            period_vld_q <= 1'b0;
            periodic_q   <= 1'b0;
            single_q     <= 1'b0;
            pcount_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pulse_prev_q <= pulse;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            periodic_q   <= periodic_d;
            single_q     <= single_d;
            pcount_q     <= pcount_d;
        end
    end

    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign periodic   = periodic_q;
    assign single_det = single_q;
    assign pcount     = pcount_q;

`ifdef PULSE_METER_JITTER_EN
    // -----------------------------------------------------------------------
    // Jitter flag
    // -----------------------------------------------------------------------
    // Only the edges inside an established train are compared. The
    // FIRST->PERIODIC edge has no earlier interval from this train to compare
    // against.
    logic jitter_q, jitter_d;

    always_comb begin
        jitter_d = meas & (state_q == ST_PERIODIC)
                   & (interval_of(cnt_q) != period_q);
    end

    always_ff @(posedge clk) begin
        if (rst) jitter_q <= 1'b0;
        else     jitter_q <= jitter_d;
    end

    assign jitter = jitter_q;
`else
    // Without the jitter option there is no comparator and no extra port.
`endif

endmodule

// File: tb/tb_pulse_meter.sv
module tb_pulse_meter;
    localparam int CW      = 16;
    localparam int TIMEOUT = 20;
    localparam int NCW     = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b1;
    logic           pulse = 1'b1;
    logic [CW-1:0]  period;
    logic           period_vld;
    logic           periodic;
    logic           single_det;
    logic [NCW-1:0] pcount;
`ifdef PULSE_METER_JITTER_EN
    logic           jitter;
`endif

    pulse_meter #(.CW(CW), .TIMEOUT(TIMEOUT), .NCW(NCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pulse      (pulse),
        .period     (period),
        .period_vld (period_vld),
        .periodic   (periodic),
        .single_det (single_det),
        .pcount     (pcount)
`ifdef PULSE_METER_JITTER_EN
        ,
        .jitter     (jitter)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model. It works from edge timestamps: it remembers when the
    // last accepted edge happened and how many edges the current burst holds.
    int m_cyc    = 0;   // step index
    bit m_prev   = 1'b1;
    int m_burst  = 0;   // 0 = nothing open, 1 = lone edge, >=2 = train
    int m_last   = 0;   // step index of last accepted edge
    int m_period = 0;
    bit m_vld    = 0;
    bit m_single = 0;
    int m_pcount = 0;
    bit m_jit    = 0;

    // Observed event tallies (used for directed end-of-phase checks)
    int single_seen = 0;
    int jit_seen    = 0;
    int vld_periods[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit p, input bit e, input bit r);
        bit edge_s;
        int ivl;
        m_vld = 0; m_single = 0; m_jit = 0;
        if (r) begin
            m_prev = 1'b1; m_burst = 0; m_period = 0; m_pcount = 0;
        end else begin
            edge_s = p && !m_prev && e;
            m_prev = p;
            if (!e) begin
                m_burst = 0;
            end else begin
                if (m_burst > 0 && !edge_s && (m_cyc - m_last) == TIMEOUT) begin
                    m_single = (m_burst == 1);
                    m_burst  = 0;
                end
                if (edge_s) begin
                    if (m_burst > 0) begin
                        ivl      = m_cyc - m_last;
                        m_jit    = (m_burst >= 2) && (ivl != m_period);
                        m_period = ivl;
                        m_vld    = 1;
                    end
                    m_burst = (m_burst >= 2) ? 2 : m_burst + 1;
                    m_last  = m_cyc;
                    if (m_pcount < 255) m_pcount++;
                end
            end
        end
        m_cyc++;
    endtask

    // One clock: drive inputs, advance the model, and compare after the edge.
    task automatic step(input bit p, input bit e, input bit r);
        @(negedge clk);
        pulse = p; en = e; rst = r;
        model(p, e, r);
        @(posedge clk);
        #1;
        check($sformatf("period@%0d", m_cyc), 32'(period), 32'(m_period));
        check($sformatf("period_vld@%0d", m_cyc), 32'(period_vld), 32'(m_vld));
        check($sformatf("periodic@%0d", m_cyc), 32'(periodic), 32'(m_burst >= 2));
        check($sformatf("single_det@%0d", m_cyc), 32'(single_det), 32'(m_single));
        check($sformatf("pcount@%0d", m_cyc), 32'(pcount), 32'(m_pcount));
`ifdef PULSE_METER_JITTER_EN
        check($sformatf("jitter@%0d", m_cyc), 32'(jitter), 32'(m_jit));
        if (jitter) jit_seen++;
`endif
        if (single_det) single_seen++;
        if (period_vld) vld_periods.push_back(int'(period));
    endtask

    task automatic pulse_gap(input int gap, input bit e);
        step(1, e, 0);
        repeat (gap - 1) step(0, e, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 1, 0);
    endtask

    task automatic check_periods(input string tag, input int exp_q[$]);
        check({tag, "_count"}, 32'(vld_periods.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < vld_periods.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(vld_periods[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int ivl;
        int wid;
        bit e_cur;

        // 1: reset with pulse high, release with pulse still high
        repeat (3) step(1, 1, 1);
        check("t1_rst_period", 32'(period), 0);
        check("t1_rst_periodic", 32'(periodic), 0);
        check("t1_rst_pcount", 32'(pcount), 0);
        repeat (4) step(1, 1, 0);
        check("t1_no_edge_pcount", 32'(pcount), 0);
        idle(3);

        // 2: lone pulse then timeout
        single_seen = 0; vld_periods.delete();
        step(1, 1, 0);
        check("t2_first_pcount", 32'(pcount), 1);
        idle(30);
        check("t2_single_count", 32'(single_seen), 1);
        check("t2_no_vld", 32'(vld_periods.size()), 0);

        // 3: five-pulse train, interval 8
        single_seen = 0; vld_periods.delete();
        repeat (5) pulse_gap(8, 1);
        idle(30);
        check_periods("t3_period", '{8, 8, 8, 8});
        check("t3_no_single", 32'(single_seen), 0);
        check("t3_pcount", 32'(pcount), 6);

        // 4: interval TIMEOUT accepted, TIMEOUT+1 times out
        single_seen = 0; vld_periods.delete();
        pulse_gap(20, 1); step(1, 1, 0); idle(30);
        check_periods("t4_period", '{20});
        check("t4_no_single", 32'(single_seen), 0);
        pulse_gap(21, 1); step(1, 1, 0); idle(30);
        check("t4_singles", 32'(single_seen), 2);
        check("t4_pcount", 32'(pcount), 10);
        check("t4_no_new_vld", 32'(vld_periods.size()), 1);

        // 5: enable control
        repeat (3) pulse_gap(8, 1);
        step(0, 0, 0);
        check("t5_periodic_off", 32'(periodic), 0);
        repeat (4) pulse_gap(3, 0);
        check("t5_pcount_hold", 32'(pcount), 13);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        check("t5_reenable_no_edge", 32'(pcount), 13);
        idle(3);
        step(1, 1, 0);
        check("t5_edge_after_reenable", 32'(pcount), 14);
        idle(30);

        // 6: intervals 8, 8, 9, 9
        jit_seen = 0; vld_periods.delete();
        pulse_gap(8, 1); pulse_gap(8, 1); pulse_gap(9, 1); pulse_gap(9, 1);
        step(1, 1, 0);
        idle(30);
        check_periods("t6_period", '{8, 8, 9, 9});
`ifdef PULSE_METER_JITTER_EN
        check("t6_jitter_count", 32'(jit_seen), 1);
`endif

        // 7: randomized bursts with occasional disable and reset
        e_cur = 1;
        for (int s = 0; s < 200; s++) begin
            ivl = $urandom_range(2, 25);
            wid = $urandom_range(1, ivl - 1);
            if ($urandom_range(0, 15) == 0) e_cur = ~e_cur;
            if ($urandom_range(0, 49) == 0) step(0, e_cur, 1);
            for (int k = 0; k < ivl; k++) step(k < wid, e_cur, 0);
        end

        // 8: pcount saturation and reset mid-train
        step(1, 1, 1);
        step(0, 1, 0);
        repeat (270) pulse_gap(2, 1);
        check("t8_pcount_sat", 32'(pcount), 255);
        check("t8_period", 32'(period), 2);
        step(1, 1, 1);
        check("t8_rst_pcount", 32'(pcount), 0);
        check("t8_rst_periodic", 32'(periodic), 0);
        check("t8_rst_period", 32'(period), 0);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
